// File: rtl/rgb_pwm_sequencer.sv
// rgb_pwm_sequencer: multi-channel LED PWM engine with off/static/chase/breathe modes
module rgb_pwm_sequencer #(
  parameter int NUM_CH = 3,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 188,
  parameter int STEP_PERIODS = 16,
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode_i,
  input  logic [NUM_CH*PWM_BITS-1:0] duty_i,
  output logic [NUM_CH-1:0]          pwm_o,
  output logic                       period_end_o,
  output logic                       step_o,
  output logic [CW-1:0]              chan_o
);
  localparam logic [1:0] M_OFF = 2'd0, M_STATIC = 2'd1, M_CHASE = 2'd2, M_BREATHE = 2'd3;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int SW = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  logic [1:0] mode_q, mode_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d, ramp_q, ramp_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic down_q, down_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [NUM_CH*PWM_BITS-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic period_end_q, period_end_d, step_q, step_d;
  logic restart, tick, wrap, seq, step, br, flip;
  logic [PWM_BITS-1:0] sh [NUM_CH];
  logic [PWM_BITS-1:0] level [NUM_CH];
  logic [2*PWM_BITS-1:0] prod [NUM_CH];
  always_comb begin
    restart = mode_i != mode_q;
    tick = mode_q != M_OFF && pre_q == PW'(PRESCALE - 1);
    wrap = tick && cnt_q == MAX;
    seq = mode_q == M_CHASE || mode_q == M_BREATHE;
    step = wrap && seq && step_cnt_q == SW'(STEP_PERIODS - 1);
    br = step && mode_q == M_BREATHE;
    flip = down_q ? ramp_q == '0 : ramp_q == MAX;
    mode_d = mode_i;
    pre_d = restart || tick || mode_q == M_OFF ? '0 : pre_q + 1'b1;
    cnt_d = restart ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
    step_cnt_d = restart || step ? '0 : wrap && seq ? step_cnt_q + 1'b1 : step_cnt_q;
    chan_d = restart ? '0 : step && mode_q == M_CHASE ? (chan_q == CW'(NUM_CH - 1) ? '0 : chan_q + 1'b1) : chan_q;
    down_d = restart ? 1'b0 : br ? down_q ^ flip : down_q;
    ramp_d = restart ? '0 : br ? (down_q ^ flip ? ramp_q - 1'b1 : ramp_q + 1'b1) : ramp_q;
    shadow_d = restart || wrap ? duty_i : shadow_q;
    for (int i = 0; i < NUM_CH; i++) begin
      sh[i] = shadow_q[i*PWM_BITS +: PWM_BITS];
      prod[i] = {{PWM_BITS{1'b0}}, sh[i]} * {{PWM_BITS{1'b0}}, ramp_q};
      level[i] = mode_q == M_STATIC ? sh[i] :
                 mode_q == M_CHASE ? (chan_q == CW'(i) ? sh[i] : '0) :
                 mode_q == M_BREATHE ? prod[i][2*PWM_BITS-1:PWM_BITS] : '0;
      pwm_d[i] = !restart && cnt_q < level[i];
    end
    period_end_d = wrap && !restart;
    step_d = step && !restart;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= M_OFF;
      pre_q <= '0;
      cnt_q <= '0;
      step_cnt_q <= '0;
      ramp_q <= '0;
      down_q <= 1'b0;
      chan_q <= '0;
      shadow_q <= '0;
      pwm_q <= '0;
      period_end_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      step_cnt_q <= step_cnt_d;
      ramp_q <= ramp_d;
      down_q <= down_d;
      chan_q <= chan_d;
      shadow_q <= shadow_d;
      pwm_q <= pwm_d;
      period_end_q <= period_end_d;
      step_q <= step_d;
    end
  end
  assign pwm_o = pwm_q;
  assign period_end_o = period_end_q;
  assign step_o = step_q;
  assign chan_o = chan_q;
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb_rgb_pwm_sequencer: scoreboard bench checking per-period high times, chan and step pulses
module tb_rgb_pwm_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] mode_i = 2'd0;
  logic [11:0] duty_i = 12'h000;
  logic [2:0] pwm_o;
  logic period_end_o, step_o;
  logic [1:0] chan_o;
  typedef struct {
    int hi0;
    int hi1;
    int hi2;
    int chan;
    int stp;
    int len;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  rgb_pwm_sequencer #(
    .NUM_CH(3),
    .PWM_BITS(4),
    .PRESCALE(2),
    .STEP_PERIODS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode_i(mode_i),
    .duty_i(duty_i),
    .pwm_o(pwm_o),
    .period_end_o(period_end_o),
    .step_o(step_o),
    .chan_o(chan_o)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic push(input int h0, input int h1, input int h2, input int ch, input int st);
    exp_t e;
    e = '{h0, h1, h2, ch, st, 32};
    q.push_back(e);
  endtask
  task automatic drain(input string name, input int lim);
    int n;
    n = 0;
    while (q.size() != 0 && n < lim) begin
      cyc();
      n++;
    end
    total++;
    if (q.size() == 0) passed++;
    else begin
      $display("FAIL %s drain: %0d periods still expected after %0d cycles", name, q.size(), lim);
      q.delete();
    end
  endtask
  initial begin
    int h [3];
    int len;
    int np;
    logic [1:0] last_mode;
    exp_t e;
    h = '{0, 0, 0};
    len = -1;
    np = 0;
    last_mode = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_mode = 2'd0;
        len = -1;
        h = '{0, 0, 0};
      end else if (mode_i != last_mode) begin
        last_mode = mode_i;
        len = -1;
        h = '{0, 0, 0};
      end else begin
        len++;
        for (int i = 0; i < 3; i++) h[i] += int'(pwm_o[i]);
        if (step_o && !period_end_o) begin
          total++;
          $display("FAIL step_alone: step_o high without period_end_o at %0t", $time);
        end
        if (period_end_o) begin
          np++;
          total++;
          if (q.size() == 0) $display("FAIL unexpected_period_end: period %0d at %0t", np, $time);
          else begin
            e = q.pop_front();
            if (h[0] == e.hi0 && h[1] == e.hi1 && h[2] == e.hi2 && int'(chan_o) == e.chan &&
                int'(step_o) == e.stp && len == e.len) passed++;
            else $display("FAIL period %0d: got hi=%0d/%0d/%0d chan=%0d step=%0d len=%0d expected hi=%0d/%0d/%0d chan=%0d step=%0d len=%0d",
                          np, h[0], h[1], h[2], chan_o, step_o, len, e.hi0, e.hi1, e.hi2, e.chan, e.stp, e.len);
          end
          h = '{0, 0, 0};
          len = 0;
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int pe, ph, s, r;
    repeat (3) cyc();
    chk("reset pwm_o", int'(pwm_o), 0);
    chk("reset period_end_o", int'(period_end_o), 0);
    chk("reset step_o", int'(step_o), 0);
    chk("reset chan_o", int'(chan_o), 0);
    rst = 1'b0;
    duty_i = 12'hF04;
    mode_i = 2'd1;
    push(8, 0, 30, 0, 0);
    push(8, 0, 30, 0, 0);
    drain("static", 200);
    repeat (10) cyc();
    duty_i = 12'hF0C;
    push(8, 0, 30, 0, 0);
    push(24, 0, 30, 0, 0);
    drain("static_duty_change", 200);
    duty_i = 12'h00F;
    mode_i = 2'd3;
    for (int k = 1; k <= 64; k++) begin
      s = (k - 1) / 2;
      r = s <= 15 ? s : s <= 30 ? 30 - s : s - 30;
      push(((15 * r) >> 4) * 2, 0, 0, 0, k % 2 == 0 ? 1 : 0);
    end
    drain("breathe", 64 * 32 + 200);
    mode_i = 2'd0;
    cyc();
    cyc();
    chk("off entry pwm_o", int'(pwm_o), 0);
    pe = 0;
    ph = 0;
    repeat (100) begin
      cyc();
      pe += int'(period_end_o);
      ph += int'(pwm_o != 3'b000);
    end
    chk("off period_end count", pe, 0);
    chk("off pwm high count", ph, 0);
    chk("off chan_o", int'(chan_o), 0);
    duty_i = 12'hF04;
    mode_i = 2'd1;
    push(8, 0, 30, 0, 0);
    drain("static_after_off", 200);
    duty_i = 12'h888;
    mode_i = 2'd2;
    push(16, 0, 0, 0, 0);
    push(16, 0, 0, 1, 1);
    push(0, 16, 0, 1, 0);
    push(0, 16, 0, 2, 1);
    push(0, 0, 16, 2, 0);
    drain("chase", 5 * 32 + 200);
    repeat (10) cyc();
    chk("chase chan before reset", int'(chan_o), 2);
    chk("chase pwm before reset", int'(pwm_o), 4);
    rst = 1'b1;
    cyc();
    chk("mid reset pwm_o", int'(pwm_o), 0);
    chk("mid reset chan_o", int'(chan_o), 0);
    chk("mid reset period_end_o", int'(period_end_o), 0);
    chk("mid reset step_o", int'(step_o), 0);
    rst = 1'b0;
    push(16, 0, 0, 0, 0);
    push(16, 0, 0, 1, 1);
    push(0, 16, 0, 1, 0);
    drain("chase_after_reset", 3 * 32 + 200);
    repeat (5) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
